alu_accumulator_stage: RTL and testbench

Sequential execution stage that sits directly upstream of the combinational ALU.
- Holds an 8-bit accumulator and presents it as operand A, with the B operand and OP from a valid/ready command port.
- Waits a programmable settle time, then captures the ALU's Y and C/V/N/Z flags back into the accumulator and a status register.
- Turns the free-running combinational ALU into a one-command-at-a-time accumulator machine driven from board inputs or a future sequencer.

---
 rtl/alu_accumulator_stage.sv | 152 +++++++++++++++
 tb/tb_alu_accumulator_stage.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_accumulator_stage.sv
// Accumulator execution stage in front of a combinational ALU. It latches one
// command at a time, holds the ALU inputs for a settle window, then captures Y and the flags.
module alu_accumulator_stage #(
    parameter int DATA_WIDTH    = 8,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                  CLK,
    input  logic                  RESET_L,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic                  IN_LOAD,
    input  logic                  IN_CLEAR,
    input  logic [2:0]            IN_OP,
    input  logic [DATA_WIDTH-1:0] IN_B,
    output logic [DATA_WIDTH-1:0] ALU_A,
    output logic [DATA_WIDTH-1:0] ALU_B,
    output logic [2:0]            ALU_OP,
    input  logic [DATA_WIDTH-1:0] ALU_Y,
    input  logic                  ALU_C,
    input  logic                  ALU_V,
    input  logic                  ALU_N,
    input  logic                  ALU_Z,
    output logic [DATA_WIDTH-1:0] ACC,
    output logic [3:0]            FLAGS,
    output logic                  OUT_VALID,
    output logic                  BUSY,
    output logic [7:0]            OP_COUNT
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);
    localparam logic [3:0] FLAGS_RESET = 4'b0001;

    // A direct load carries no carry/overflow information, only sign and zero.
    function automatic logic [3:0] load_flags(input logic [DATA_WIDTH-1:0] value);
        return {1'b0, 1'b0, value[DATA_WIDTH-1], (value == {DATA_WIDTH{1'b0}})};
    endfunction

    state_t                  state_r, state_n;
    logic [3:0]              cnt_r, cnt_n;
    logic [DATA_WIDTH-1:0]   acc_r, acc_n;
    logic [3:0]              flags_r, flags_n;
    logic [DATA_WIDTH-1:0]   alu_a_r, alu_a_n;
    logic [DATA_WIDTH-1:0]   alu_b_r, alu_b_n;
    logic [2:0]              alu_op_r, alu_op_n;
    logic                    out_valid_r, out_valid_n;
    logic [7:0]              op_count_r, op_count_n;
    logic                    in_ready_s;
    logic                    accept_s;

    assign in_ready_s = (state_r == ST_IDLE) && !IN_CLEAR;
    assign accept_s   = IN_VALID && in_ready_s;

    // Next-state and next-register computation; clear overrides every state.
    always_comb begin
        state_n     = state_r;
        cnt_n       = cnt_r;
        acc_n       = acc_r;
        flags_n     = flags_r;
        alu_a_n     = alu_a_r;
        alu_b_n     = alu_b_r;
        alu_op_n    = alu_op_r;
        out_valid_n = 1'b0;
        op_count_n  = op_count_r;
        if (IN_CLEAR) begin
            state_n = ST_IDLE;
            cnt_n   = 4'd0;
            acc_n   = {DATA_WIDTH{1'b0}};
            flags_n = FLAGS_RESET;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && IN_LOAD) begin
                        acc_n       = IN_B;
                        flags_n     = load_flags(IN_B);
                        out_valid_n = 1'b1;
                        op_count_n  = op_count_r + 8'd1;
                    end else if (accept_s) begin
                        alu_a_n  = acc_r;
                        alu_b_n  = IN_B;
                        alu_op_n = IN_OP;
                        cnt_n    = SETTLE_INIT;
                        state_n  = ST_SETTLE;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    cnt_n = cnt_r - 4'd1;
                    if (cnt_r <= 4'd1) begin
                        state_n = ST_CAPTURE;
                    end else begin
                        state_n = ST_SETTLE;
                    end
                end
                ST_CAPTURE: begin
                    acc_n       = ALU_Y;
                    flags_n     = {ALU_C, ALU_V, ALU_N, ALU_Z};
                    out_valid_n = 1'b1;
                    op_count_n  = op_count_r + 8'd1;
                    cnt_n       = 4'd0;
                    state_n     = ST_IDLE;
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = 4'd0;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            acc_r       <= {DATA_WIDTH{1'b0}};
            flags_r     <= FLAGS_RESET;
            alu_a_r     <= {DATA_WIDTH{1'b0}};
            alu_b_r     <= {DATA_WIDTH{1'b0}};
            alu_op_r    <= 3'd0;
            out_valid_r <= 1'b0;
            op_count_r  <= 8'd0;
        end else begin
            state_r     <= state_n;
            cnt_r       <= cnt_n;
            acc_r       <= acc_n;
            flags_r     <= flags_n;
            alu_a_r     <= alu_a_n;
            alu_b_r     <= alu_b_n;
            alu_op_r    <= alu_op_n;
            out_valid_r <= out_valid_n;
            op_count_r  <= op_count_n;
        end
    end

    assign IN_READY  = in_ready_s;
    assign BUSY      = (state_r != ST_IDLE);
    assign ALU_A     = alu_a_r;
    assign ALU_B     = alu_b_r;
    assign ALU_OP    = alu_op_r;
    assign ACC       = acc_r;
    assign FLAGS     = flags_r;
    assign OUT_VALID = out_valid_r;
    assign OP_COUNT  = op_count_r;

endmodule

// File: tb/tb_alu_accumulator_stage.sv
// Bench for alu_accumulator_stage: two instances (settle 1 and 3) driven by
// random commands and compared with a transaction-level accumulator model.
module tb_alu_accumulator_stage;

    logic              clk_s = 1'b0;
    logic              rst_n_s;
    logic [1:0]        in_valid_s, in_load_s, in_clear_s;
    logic [1:0][2:0]   in_op_s;
    logic [1:0][7:0]   in_b_s;
    wire  [1:0]        in_ready_s, out_valid_s, busy_s;
    wire  [1:0][7:0]   alu_a_s, alu_b_s, acc_s, op_count_s;
    wire  [1:0][2:0]   alu_op_s;
    wire  [1:0][3:0]   flags_s;
    wire  [1:0][11:0]  alu_res_s;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] acc_m [2];
    logic [3:0] flags_m [2];
    logic [7:0] opc_m [2];
    int         settle_m [2];

    always #5 clk_s = ~clk_s;

    // Reference ALU: returns {C,V,N,Z,Y}.
    function automatic logic [11:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                            input logic [2:0] op);
        int s;
        logic [7:0] y;
        logic c, v;
        c = 1'b0; v = 1'b0; y = 8'd0; s = 0;
        case (op)
            3'd0: begin s = int'(a) + int'(b); y = 8'(s); c = (s > 255);
                        v = (a[7] == b[7]) && (y[7] != a[7]); end
            3'd1: begin y = 8'(int'(a) - int'(b)); c = (a < b);
                        v = (a[7] != b[7]) && (y[7] != a[7]); end
            3'd2: y = a & b;
            3'd3: y = a | b;
            3'd4: y = a ^ b;
            3'd5: begin y = a << 1; c = a[7]; end
            3'd6: begin y = a >> 1; c = a[0]; end
            default: y = b;
        endcase
        return {c, v, y[7], (y == 8'd0), y};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign alu_res_s[g] = alu_ref(alu_a_s[g], alu_b_s[g], alu_op_s[g]);
        alu_accumulator_stage #(.DATA_WIDTH(8), .SETTLE_CYCLES(g == 0 ? 1 : 3)) u_dut (
            .CLK(clk_s), .RESET_L(rst_n_s),
            .IN_VALID(in_valid_s[g]), .IN_READY(in_ready_s[g]),
            .IN_LOAD(in_load_s[g]), .IN_CLEAR(in_clear_s[g]),
            .IN_OP(in_op_s[g]), .IN_B(in_b_s[g]),
            .ALU_A(alu_a_s[g]), .ALU_B(alu_b_s[g]), .ALU_OP(alu_op_s[g]),
            .ALU_Y(alu_res_s[g][7:0]), .ALU_C(alu_res_s[g][11]), .ALU_V(alu_res_s[g][10]),
            .ALU_N(alu_res_s[g][9]), .ALU_Z(alu_res_s[g][8]),
            .ACC(acc_s[g]), .FLAGS(flags_s[g]), .OUT_VALID(out_valid_s[g]),
            .BUSY(busy_s[g]), .OP_COUNT(op_count_s[g])
        );
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_s);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            acc_m[k] = 8'h00; flags_m[k] = 4'b0001; opc_m[k] = 8'h00;
        end
    endtask

    task automatic wait_ready(input int k);
        int n;
        n = 0;
        while (!in_ready_s[k] && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready_s[k]) check_value("ready_timeout", 32'(in_ready_s[k]), 32'd1);
    endtask

    task automatic do_load(input int k, input logic [7:0] v);
        wait_ready(k);
        in_valid_s[k] = 1'b1; in_load_s[k] = 1'b1; in_b_s[k] = v; in_op_s[k] = 3'($urandom);
        tick();
        in_valid_s[k] = 1'b0;
        acc_m[k]   = v;
        flags_m[k] = {2'b00, v[7], (v == 8'd0)};
        opc_m[k]   = opc_m[k] + 8'd1;
        check_value("load_acc", 32'(acc_s[k]), 32'(acc_m[k]));
        check_value("load_flags", 32'(flags_s[k]), 32'(flags_m[k]));
        check_value("load_out_valid", 32'(out_valid_s[k]), 32'd1);
        check_value("load_op_count", 32'(op_count_s[k]), 32'(opc_m[k]));
        check_value("load_busy", 32'(busy_s[k]), 32'd0);
    endtask

    task automatic do_alu(input int k, input logic [7:0] b, input logic [2:0] op);
        logic [11:0] r;
        logic [7:0]  a;
        wait_ready(k);
        a = acc_m[k];
        r = alu_ref(a, b, op);
        in_valid_s[k] = 1'b1; in_load_s[k] = 1'b0; in_b_s[k] = b; in_op_s[k] = op;
        tick();
        in_valid_s[k] = 1'b0; in_b_s[k] = 8'($urandom); in_op_s[k] = 3'($urandom);
        check_value("alu_a_latch", 32'(alu_a_s[k]), 32'(a));
        check_value("alu_b_latch", 32'(alu_b_s[k]), 32'(b));
        check_value("alu_op_latch", 32'(alu_op_s[k]), 32'(op));
        check_value("alu_busy", 32'(busy_s[k]), 32'd1);
        for (int i = 0; i < settle_m[k]; i++) begin
            check_value("alu_wait_ov", 32'(out_valid_s[k]), 32'd0);
            check_value("alu_wait_ready", 32'(in_ready_s[k]), 32'd0);
            check_value("alu_wait_acc", 32'(acc_s[k]), 32'(a));
            tick();
            check_value("alu_hold_a", 32'(alu_a_s[k]), 32'(a));
        end
        check_value("alu_capture_early", 32'(out_valid_s[k]), 32'd0);
        tick();
        acc_m[k]   = r[7:0];
        flags_m[k] = r[11:8];
        opc_m[k]   = opc_m[k] + 8'd1;
        check_value("alu_acc", 32'(acc_s[k]), 32'(acc_m[k]));
        check_value("alu_flags", 32'(flags_s[k]), 32'(flags_m[k]));
        check_value("alu_out_valid", 32'(out_valid_s[k]), 32'd1);
        check_value("alu_op_count", 32'(op_count_s[k]), 32'(opc_m[k]));
        check_value("alu_ready_after", 32'(in_ready_s[k]), 32'd1);
    endtask

    initial begin
        int pulses;
        logic [7:0] saved_opc;
        logic [11:0] r;
        settle_m[0] = 1; settle_m[1] = 3;
        in_valid_s = 2'b00; in_load_s = 2'b00; in_clear_s = 2'b00;
        in_op_s = '0; in_b_s = '0;
        rst_n_s = 1'b0;
        model_reset();
        tick(); tick();
        for (int k = 0; k < 2; k++) begin
            check_value("rst_acc", 32'(acc_s[k]), 32'h00);
            check_value("rst_flags", 32'(flags_s[k]), 32'h1);
            check_value("rst_alu_a", 32'(alu_a_s[k]), 32'h00);
            check_value("rst_alu_op", 32'(alu_op_s[k]), 32'h0);
            check_value("rst_out_valid", 32'(out_valid_s[k]), 32'd0);
            check_value("rst_op_count", 32'(op_count_s[k]), 32'd0);
        end
        rst_n_s = 1'b1;
        tick();
        check_value("idle_ready", 32'(in_ready_s[0]), 32'd1);

        // Directed loads: sign flag and zero flag.
        do_load(0, 8'h80);
        tick();
        check_value("load_pulse_end", 32'(out_valid_s[0]), 32'd0);
        do_load(0, 8'h00);

        // Add with carry, both settle lengths.
        for (int k = 0; k < 2; k++) begin
            do_load(k, 8'hF0);
            do_alu(k, 8'h20, 3'd0);
            check_value("add_acc_10", 32'(acc_s[k]), 32'h10);
            check_value("add_flags_c", 32'(flags_s[k]), 32'b1000);
        end

        // Backpressure: second command held valid until accepted in the OUT_VALID cycle.
        do_load(0, 8'hF0);
        in_valid_s[0] = 1'b1; in_load_s[0] = 1'b0; in_b_s[0] = 8'h20; in_op_s[0] = 3'd0;
        tick();
        in_b_s[0] = 8'h01;
        check_value("bp_alu_b", 32'(alu_b_s[0]), 32'h20);
        check_value("bp_ready_settle", 32'(in_ready_s[0]), 32'd0);
        tick();
        check_value("bp_ready_capture", 32'(in_ready_s[0]), 32'd0);
        check_value("bp_alu_b_hold", 32'(alu_b_s[0]), 32'h20);
        tick();
        check_value("bp_acc", 32'(acc_s[0]), 32'h10);
        check_value("bp_ov", 32'(out_valid_s[0]), 32'd1);
        check_value("bp_ready_ov", 32'(in_ready_s[0]), 32'd1);
        tick();
        in_valid_s[0] = 1'b0;
        check_value("bp_second_a", 32'(alu_a_s[0]), 32'h10);
        check_value("bp_second_b", 32'(alu_b_s[0]), 32'h01);
        check_value("bp_second_busy", 32'(busy_s[0]), 32'd1);
        tick(); tick();
        r = alu_ref(8'h10, 8'h01, 3'd0);
        acc_m[0] = r[7:0]; flags_m[0] = r[11:8]; opc_m[0] = opc_m[0] + 8'd2;
        check_value("bp_second_acc", 32'(acc_s[0]), 32'h11);
        check_value("bp_second_flags", 32'(flags_s[0]), 32'(flags_m[0]));
        check_value("bp_op_count", 32'(op_count_s[0]), 32'(opc_m[0]));

        // Clear mid-SETTLE drops the operation.
        do_load(1, 8'h55);
        saved_opc = opc_m[1];
        in_valid_s[1] = 1'b1; in_load_s[1] = 1'b0; in_b_s[1] = 8'h11; in_op_s[1] = 3'd0;
        tick();
        in_valid_s[1] = 1'b0;
        tick();
        in_clear_s[1] = 1'b1;
        tick();
        in_clear_s[1] = 1'b0;
        acc_m[1] = 8'h00; flags_m[1] = 4'b0001;
        check_value("clr_acc", 32'(acc_s[1]), 32'h00);
        check_value("clr_flags", 32'(flags_s[1]), 32'h1);
        check_value("clr_busy", 32'(busy_s[1]), 32'd0);
        check_value("clr_ov", 32'(out_valid_s[1]), 32'd0);
        check_value("clr_op_count", 32'(op_count_s[1]), 32'(saved_opc));
        for (int i = 0; i < 4; i++) begin
            tick();
            check_value("clr_no_capture", 32'(out_valid_s[1]), 32'd0);
        end
        // Clear while idle wins over a simultaneous load.
        do_load(1, 8'h33);
        in_clear_s[1] = 1'b1; in_valid_s[1] = 1'b1; in_load_s[1] = 1'b1; in_b_s[1] = 8'h77;
        #1;
        check_value("clr_ready_low", 32'(in_ready_s[1]), 32'd0);
        tick();
        in_clear_s[1] = 1'b0; in_valid_s[1] = 1'b0;
        acc_m[1] = 8'h00; flags_m[1] = 4'b0001;
        check_value("clr_over_load_acc", 32'(acc_s[1]), 32'h00);
        check_value("clr_over_load_opc", 32'(op_count_s[1]), 32'(opc_m[1]));

        // Random command streams.
        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 40; n++) begin
                if ($urandom_range(0, 3) == 0) do_load(k, 8'($urandom));
                else do_alu(k, 8'($urandom), 3'($urandom));
                if ($urandom_range(0, 1) == 1) begin
                    tick();
                    check_value("rand_idle_ov", 32'(out_valid_s[k]), 32'd0);
                end
            end
        end

        // Reset in the middle of SETTLE.
        do_load(1, 8'h5A);
        in_valid_s[1] = 1'b1; in_load_s[1] = 1'b0; in_b_s[1] = 8'h01; in_op_s[1] = 3'd0;
        tick();
        in_valid_s[1] = 1'b0;
        #2 rst_n_s = 1'b0;
        #1;
        model_reset();
        check_value("mid_rst_acc", 32'(acc_s[1]), 32'h00);
        check_value("mid_rst_flags", 32'(flags_s[1]), 32'h1);
        check_value("mid_rst_busy", 32'(busy_s[1]), 32'd0);
        check_value("mid_rst_opc", 32'(op_count_s[1]), 32'd0);
        check_value("mid_rst_alu_a", 32'(alu_a_s[1]), 32'd0);
        tick();
        rst_n_s = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_value("post_rst_no_ov", 32'(out_valid_s[1]), 32'd0);
        end

        // 256 back-to-back loads wrap OP_COUNT.
        pulses = 0;
        in_valid_s[0] = 1'b1; in_load_s[0] = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in_b_s[0] = 8'(i) ^ 8'hA5;
            tick();
            pulses += int'(out_valid_s[0]);
            check_value("wrap_acc", 32'(acc_s[0]), 32'(8'(i) ^ 8'hA5));
        end
        in_valid_s[0] = 1'b0;
        check_value("wrap_op_count", 32'(op_count_s[0]), 32'h00);
        check_value("wrap_pulses", 32'(pulses), 32'd256);
        tick();
        check_value("wrap_ov_end", 32'(out_valid_s[0]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
